// File: rtl/timestamp_scheduler.sv
// timestamp_scheduler: free-running pixel-domain timestamp with start/stop,
// synchronous clear and offset load, plus NUM_CH independent compare channels.
// Each channel queues scheduled timestamps and pulses event_out when the
// counter reaches the head entry; late_err records entries that fired after
// their time had already passed.
module timestamp_scheduler #(
    parameter int unsigned COUNTER_WIDTH = 64,
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter int unsigned FIFO_ADDR_LEN = 3
) (
    input  logic                            clk_pixel,
    input  logic                            rtio_resetn,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            stop,
    input  logic                            offset_en,
    input  logic [COUNTER_WIDTH-1:0]        counter_offset,
    output logic [COUNTER_WIDTH-1:0]        counter,
    output logic                            running,
    input  logic [NUM_CH-1:0]               ts_valid,
    input  logic [NUM_CH*COUNTER_WIDTH-1:0] ts_data,
    output logic [NUM_CH-1:0]               ts_ready,
    output logic [NUM_CH-1:0]               fifo_empty,
    output logic [NUM_CH-1:0]               event_out,
    output logic [NUM_CH-1:0]               late_err
);

    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);
    localparam logic [FIFO_ADDR_LEN:0]   PTR_ONE = (FIFO_ADDR_LEN + 1)'(1);

    typedef enum logic {
        ST_STOPPED = 1'b0,
        ST_RUNNING = 1'b1
    } run_state_t;

    run_state_t state_q, state_d;

    assign running = (state_q == ST_RUNNING);

    // Run-state register.
    always_ff @(posedge clk_pixel or negedge rtio_resetn) begin
        if (!rtio_resetn) begin
            state_q <= ST_STOPPED;
        end else begin
            state_q <= state_d;
        end
    end

    // Next run state: clear > offset load (keeps state) > stop > start.
    always_comb begin
        state_d = state_q;
        if (reset) begin
            state_d = ST_STOPPED;
        end else if (offset_en) begin
            state_d = state_q;
        end else if (stop) begin
            state_d = ST_STOPPED;
        end else if (start) begin
            state_d = ST_RUNNING;
        end
    end

    // Timestamp counter: clear > load > hold on stop > increment while running.
    always_ff @(posedge clk_pixel or negedge rtio_resetn) begin
        if (!rtio_resetn) begin
            counter <= '0;
        end else if (reset) begin
            counter <= '0;
        end else if (offset_en) begin
            counter <= counter_offset;
        end else if (stop) begin
            counter <= counter;
        end else if (running) begin
            counter <= counter + CNT_ONE;
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic [FIFO_ADDR_LEN:0]   wr_ptr;
        logic [FIFO_ADDR_LEN:0]   rd_ptr;
        logic [COUNTER_WIDTH-1:0] mem [FIFO_DEPTH];
        logic [COUNTER_WIDTH-1:0] head;
        logic                     empty;
        logic                     full;
        logic                     push;
        logic                     pop;
        logic                     ev_q;
        logic                     late_q;

        // Occupancy flags and the compare against the pre-edge counter.
        always_comb begin
            empty = (wr_ptr == rd_ptr);
            full  = (wr_ptr[FIFO_ADDR_LEN] != rd_ptr[FIFO_ADDR_LEN]) &&
                    (wr_ptr[FIFO_ADDR_LEN-1:0] == rd_ptr[FIFO_ADDR_LEN-1:0]);
            head  = mem[rd_ptr[FIFO_ADDR_LEN-1:0]];
            push  = ts_valid[ch] && !full;
            pop   = running && !empty && (head <= counter);
        end

        assign ts_ready[ch]   = !full;
        assign fifo_empty[ch] = empty;
        assign event_out[ch]  = ev_q;
        assign late_err[ch]   = late_q;

        // Pointers, event pulse and sticky late flag.
        always_ff @(posedge clk_pixel or negedge rtio_resetn) begin
            if (!rtio_resetn) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                ev_q   <= 1'b0;
                late_q <= 1'b0;
            end else if (reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                ev_q   <= 1'b0;
                late_q <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
                ev_q <= pop;
                if (pop && (head < counter)) begin
                    late_q <= 1'b1;
                end
            end
        end

        // Entry storage; contents beyond the pointers are don't-care, so no reset.
        always_ff @(posedge clk_pixel) begin
            if (push && !reset) begin
                mem[wr_ptr[FIFO_ADDR_LEN-1:0]] <= ts_data[ch*COUNTER_WIDTH +: COUNTER_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_timestamp_scheduler.sv
// Testbench for timestamp_scheduler: a 64-bit/4-channel instance checked
// against a queue-based reference model, plus an 8-bit instance for wrap.
module tb_timestamp_scheduler;

    logic         clk_pixel = 1'b0;
    logic         rtio_resetn;
    logic         reset, start, stop, offset_en;
    logic [63:0]  counter_offset;
    logic [63:0]  counter;
    logic         running;
    logic [3:0]   ts_valid;
    logic [255:0] ts_data;
    logic [3:0]   ts_ready, fifo_empty, event_out, late_err;

    logic         s_reset, s_start, s_stop, s_offset_en;
    logic [7:0]   s_counter_offset, s_counter;
    logic         s_running;
    logic [1:0]   s_ts_valid;
    logic [15:0]  s_ts_data;
    logic [1:0]   s_ts_ready, s_fifo_empty, s_event_out, s_late_err;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic [63:0] m_cnt;
    logic        m_run;
    logic [63:0] m_q [4][$];
    logic [3:0]  m_ev, m_late;

    always #5 clk_pixel = ~clk_pixel;

    timestamp_scheduler #(
        .COUNTER_WIDTH(64), .NUM_CH(4), .FIFO_DEPTH(8), .FIFO_ADDR_LEN(3)
    ) u_dut (
        .clk_pixel(clk_pixel), .rtio_resetn(rtio_resetn), .reset(reset),
        .start(start), .stop(stop), .offset_en(offset_en),
        .counter_offset(counter_offset), .counter(counter), .running(running),
        .ts_valid(ts_valid), .ts_data(ts_data), .ts_ready(ts_ready),
        .fifo_empty(fifo_empty), .event_out(event_out), .late_err(late_err)
    );

    timestamp_scheduler #(
        .COUNTER_WIDTH(8), .NUM_CH(2), .FIFO_DEPTH(4), .FIFO_ADDR_LEN(2)
    ) u_small (
        .clk_pixel(clk_pixel), .rtio_resetn(rtio_resetn), .reset(s_reset),
        .start(s_start), .stop(s_stop), .offset_en(s_offset_en),
        .counter_offset(s_counter_offset), .counter(s_counter), .running(s_running),
        .ts_valid(s_ts_valid), .ts_data(s_ts_data), .ts_ready(s_ts_ready),
        .fifo_empty(s_fifo_empty), .event_out(s_event_out), .late_err(s_late_err)
    );

    task automatic model_clear();
        m_cnt  = '0;
        m_run  = 1'b0;
        m_ev   = '0;
        m_late = '0;
        for (int c = 0; c < 4; c++) m_q[c].delete();
    endtask

    // Advance the model by one edge using the currently driven inputs.
    task automatic model_step();
        logic [3:0] ev;
        int         sz;
        ev = '0;
        if (reset) begin
            model_clear();
            return;
        end
        for (int c = 0; c < 4; c++) begin
            sz = m_q[c].size();
            if (m_run && sz != 0 && m_q[c][0] <= m_cnt) begin
                ev[c] = 1'b1;
                if (m_q[c][0] < m_cnt) m_late[c] = 1'b1;
                void'(m_q[c].pop_front());
            end
            if (ts_valid[c] && sz < 8) m_q[c].push_back(ts_data[c*64 +: 64]);
        end
        m_ev = ev;
        if (offset_en)  m_cnt = counter_offset;
        else if (stop)  m_cnt = m_cnt;
        else if (m_run) m_cnt = m_cnt + 64'd1;
        if (offset_en)  m_run = m_run;
        else if (stop)  m_run = 1'b0;
        else if (start) m_run = 1'b1;
    endtask

    function automatic logic [80:0] model_out();
        logic [3:0] rdy, emp;
        for (int c = 0; c < 4; c++) begin
            rdy[c] = (m_q[c].size() < 8);
            emp[c] = (m_q[c].size() == 0);
        end
        return {m_cnt, m_run, rdy, emp, m_ev, m_late};
    endfunction

    function automatic logic [80:0] dut_out();
        return {counter, running, ts_ready, fifo_empty, event_out, late_err};
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic clear_inputs();
        reset = 0; start = 0; stop = 0; offset_en = 0; counter_offset = '0;
        ts_valid = '0; ts_data = '0;
        s_reset = 0; s_start = 0; s_stop = 0; s_offset_en = 0; s_counter_offset = '0;
        s_ts_valid = '0; s_ts_data = '0;
    endtask

    task automatic test_reset();
        logic [80:0] exp_rst;
        exp_rst = {64'd0, 1'b0, 4'hF, 4'hF, 4'h0, 4'h0};
        clear_inputs();
        rtio_resetn = 1'b0;
        model_clear();
        #12;
        n_cmp++;
        if (dut_out() !== exp_rst) begin
            n_fail++;
            $display("FAIL async_reset: got %h want %h", dut_out(), exp_rst);
        end
        n_cmp++;
        if ({s_counter, s_running, s_fifo_empty, s_ts_ready} !== {8'h00, 1'b0, 2'b11, 2'b11}) begin
            n_fail++;
            $display("FAIL async_reset_small: got %h want %h",
                     {s_counter, s_running, s_fifo_empty, s_ts_ready}, {8'h00, 1'b0, 2'b11, 2'b11});
        end
        @(negedge clk_pixel);
        rtio_resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (dut_out() !== model_out()) begin
                n_fail++;
                $display("FAIL reset_release: got %h want %h", dut_out(), model_out());
            end
        end
    endtask

    task automatic test_start_stop();
        start = 1; tick(); start = 0;
        n_cmp++;
        if ({running, counter} !== {1'b1, 64'd0}) begin
            n_fail++;
            $display("FAIL start_edge: got %h want %h", {running, counter}, {1'b1, 64'd0});
        end
        for (int k = 1; k <= 9; k++) begin
            tick();
            n_cmp++;
            if (dut_out() !== model_out()) begin
                n_fail++;
                $display("FAIL count_run k=%0d: got %h want %h", k, dut_out(), model_out());
            end
            if (k == 1 || k == 5) begin
                n_cmp++;
                if (counter !== 64'(k)) begin
                    n_fail++;
                    $display("FAIL count_value k=%0d: got %0d want %0d", k, counter, k);
                end
            end
        end
        for (int s = 0; s < 2; s++) begin
            stop = 1; tick(); stop = 0;
            n_cmp++;
            if ({running, counter} !== {1'b0, 64'd9}) begin
                n_fail++;
                $display("FAIL stop_hold s=%0d: got %h want %h", s, {running, counter}, {1'b0, 64'd9});
            end
        end
    endtask

    task automatic test_schedule();
        logic [63:0] seen [$];
        reset = 1; tick(); reset = 0;
        start = 1; tick(); start = 0;
        for (int i = 0; i < 5; i++) tick();
        n_cmp++;
        if (counter !== 64'd5) begin
            n_fail++;
            $display("FAIL sched_pre: got %0d want 5", counter);
        end
        for (int i = 0; i < 3; i++) begin
            ts_valid = 4'b0001;
            ts_data  = '0;
            ts_data[63:0] = (i == 0) ? 64'd20 : 64'd25;
            tick();
        end
        ts_valid = '0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (event_out[0]) seen.push_back(counter);
            n_cmp++;
            if (dut_out() !== model_out()) begin
                n_fail++;
                $display("FAIL sched_cycle %0d: got %h want %h", i, dut_out(), model_out());
            end
        end
        n_cmp++;
        if (seen.size() != 3 || seen[0] !== 64'd21 || seen[1] !== 64'd26 || seen[2] !== 64'd27) begin
            n_fail++;
            $display("FAIL sched_events: got %0d events want 3 at counter 21,26,27", seen.size());
        end
        n_cmp++;
        if ({late_err[0], fifo_empty[0]} !== 2'b11) begin
            n_fail++;
            $display("FAIL sched_final: got %b want 11", {late_err[0], fifo_empty[0]});
        end
    endtask

    task automatic test_full_offset();
        int n_ev2, n_other;
        n_ev2 = 0; n_other = 0;
        reset = 1; tick(); reset = 0;
        for (int k = 0; k < 9; k++) begin
            ts_valid = 4'b0100;
            ts_data  = '0;
            ts_data[128 +: 64] = (k < 8) ? 64'(100 + k) : 64'd999;
            tick();
            n_cmp++;
            if (dut_out() !== model_out()) begin
                n_fail++;
                $display("FAIL fill k=%0d: got %h want %h", k, dut_out(), model_out());
            end
        end
        ts_valid = '0;
        n_cmp++;
        if (ts_ready !== 4'b1011) begin
            n_fail++;
            $display("FAIL full_ready: got %b want 1011", ts_ready);
        end
        offset_en = 1; counter_offset = 64'd200; tick(); offset_en = 0;
        start = 1; tick(); start = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (event_out[2]) n_ev2++;
            if (event_out[0] || event_out[1] || event_out[3]) n_other++;
            n_cmp++;
            if (dut_out() !== model_out()) begin
                n_fail++;
                $display("FAIL drain %0d: got %h want %h", i, dut_out(), model_out());
            end
        end
        n_cmp++;
        if (n_ev2 != 8 || n_other != 0 || late_err !== 4'b0100) begin
            n_fail++;
            $display("FAIL late_drain: got ev=%0d other=%0d late=%b want ev=8 other=0 late=0100",
                     n_ev2, n_other, late_err);
        end
    endtask

    task automatic test_reset_mid();
        logic [80:0] exp_rst;
        exp_rst = {64'd0, 1'b0, 4'hF, 4'hF, 4'h0, 4'h0};
        reset = 1; tick(); reset = 0;
        start = 1; tick(); start = 0;
        for (int i = 0; i < 3; i++) begin
            ts_valid = (i == 0) ? 4'b1011 : 4'b0010;
            ts_data  = '0;
            ts_data[64 +: 64]  = 64'(1000 + i);
            ts_data[0 +: 64]   = 64'd50;
            ts_data[192 +: 64] = 64'd0;
            tick();
        end
        ts_valid = '0;
        while (m_cnt != 64'd50) begin
            tick();
            n_cmp++;
            if (dut_out() !== model_out()) begin
                n_fail++;
                $display("FAIL mid_run: got %h want %h", dut_out(), model_out());
            end
        end
        n_cmp++;
        if ({counter, late_err[3], fifo_empty[1], fifo_empty[0]} !== {64'd50, 3'b100}) begin
            n_fail++;
            $display("FAIL mid_pre: got %h want %h",
                     {counter, late_err[3], fifo_empty[1], fifo_empty[0]}, {64'd50, 3'b100});
        end
        reset = 1; tick(); reset = 0;
        n_cmp++;
        if (dut_out() !== exp_rst) begin
            n_fail++;
            $display("FAIL mid_reset: got %h want %h", dut_out(), exp_rst);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_cnt [8];
        logic [1:0] exp_ev  [8];
        s_reset = 1; tick(); s_reset = 0;
        s_offset_en = 1; s_counter_offset = 8'hFE; tick(); s_offset_en = 0;
        n_cmp++;
        if ({s_counter, s_running} !== {8'hFE, 1'b0}) begin
            n_fail++;
            $display("FAIL wrap_load: got %h want %h", {s_counter, s_running}, {8'hFE, 1'b0});
        end
        s_start = 1; tick(); s_start = 0;
        exp_cnt = '{8'hFF, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        exp_ev  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
        for (int i = 0; i < 8; i++) begin
            s_ts_valid = (i == 2) ? 2'b01 : 2'b00;
            s_ts_data  = 16'h0003;
            tick();
            n_cmp++;
            if ({s_counter, s_event_out, s_late_err} !== {exp_cnt[i], exp_ev[i], 2'b00}) begin
                n_fail++;
                $display("FAIL wrap_step %0d: got %h want %h", i,
                         {s_counter, s_event_out, s_late_err}, {exp_cnt[i], exp_ev[i], 2'b00});
            end
        end
        s_ts_valid = '0;
        n_cmp++;
        if (s_fifo_empty !== 2'b11) begin
            n_fail++;
            $display("FAIL wrap_empty: got %b want 11", s_fifo_empty);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 63) == 0);
            offset_en = ($urandom_range(0, 31) == 0);
            stop      = ($urandom_range(0, 15) == 0);
            start     = ($urandom_range(0, 3) == 0);
            counter_offset = m_cnt + 64'($urandom_range(0, 40)) - 64'd20;
            ts_valid  = 4'($urandom_range(0, 15));
            for (int c = 0; c < 4; c++)
                ts_data[c*64 +: 64] = m_cnt + 64'($urandom_range(0, 30)) - 64'd4;
            tick();
            n_cmp++;
            if (dut_out() !== model_out()) begin
                n_fail++;
                $display("FAIL random %0d: got %h want %h", i, dut_out(), model_out());
            end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_start_stop();
        test_schedule();
        test_full_offset();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/timestamp_scheduler.md
Name: timestamp_scheduler

Overview:
- Parametrised successor of the pixel-domain timestamp counter.
- Provides a free-running timestamp of configurable width with start, stop, synchronous clear and offset load.
- Adds NUM_CH independent compare channels. Each channel buffers up to FIFO_DEPTH scheduled timestamps and emits a one-cycle event pulse when the counter reaches the head entry.
- Sits in the clk_pixel domain. Control inputs arrive already synchronised from the AXI-side register block.

Parameters:
- COUNTER_WIDTH, 64, width of counter and of every timestamp.
- NUM_CH, 4, number of compare channels.
- FIFO_DEPTH, 8, timestamp entries per channel; must be a power of two, at least 2.
- FIFO_ADDR_LEN, 3, log2(FIFO_DEPTH).

Ports:
- clk_pixel  in  1  sole clock.
- rtio_resetn  in  1  asynchronous, active-low reset.
- reset  in  1  synchronous clear: counter, running state, FIFOs, error flags.
- start  in  1  pulse; begin counting.
- stop  in  1  pulse; freeze counter.
- offset_en  in  1  load counter_offset into counter.
- counter_offset  in  COUNTER_WIDTH  load value.
- counter  out  COUNTER_WIDTH  current timestamp, registered.
- running  out  1  counter is advancing.
- ts_valid  in  NUM_CH  per-channel push request.
- ts_data  in  NUM_CH*COUNTER_WIDTH  per-channel timestamp; channel i occupies [i*W +: W].
- ts_ready  out  NUM_CH  channel FIFO not full.
- fifo_empty  out  NUM_CH  channel FIFO empty.
- event_out  out  NUM_CH  one-cycle event pulse.
- late_err  out  NUM_CH  sticky; an event fired after its timestamp had passed.

Behaviour:
- Async reset (rtio_resetn=0): counter=0, running=0, FIFOs empty, ts_ready=all 1, fifo_empty=all 1, event_out=0, late_err=0.
- Control priority per edge: reset > offset_en > stop > start > increment.
- reset=1: same state as async reset, applied on the edge.
- offset_en=1: counter<=counter_offset; running unchanged; no increment that cycle.
- stop=1: running<=0; counter holds.
- start=1: running<=1. No effect if already running.
- Increment: when running=1 (pre-edge value), counter<=counter+1 modulo 2^COUNTER_WIDTH.
- Timing: start sampled at edge k gives running=1 after edge k. The first increment occurs at edge k+1.
- Push handshake: an entry is accepted on an edge when ts_valid[i] && ts_ready[i].
  - ts_ready[i]=0 when the FIFO is full. A pop on the same edge does not re-open ready for that edge.
  - Pushes while stopped are allowed.
- Compare condition per channel, evaluated each edge: running=1 && !empty && head<=counter, unsigned compare on pre-edge values.
- On that edge:
  - pop the head;
  - event_out[i]<=1 for exactly one cycle;
  - if head<counter (strictly), late_err[i]<=1, sticky until reset.
- Latency:
  - An event fires the cycle after counter outputs T.
  - A newly pushed entry is compare-visible one cycle after acceptance.
- At most one pop per channel per cycle. Duplicate timestamps fire on consecutive cycles; the second sets late_err.
- Stopped counter: no compares, no events; FIFO contents retained.
- Offset load backward: pending entries wait until reached.
- Offset load forward past entries: those entries fire late, one per cycle, setting late_err.
- Wrap-around: the compare is not wrap-aware. After the counter wraps, entries above the counter wait until reached again. Software must avoid scheduling across a wrap.
- Simultaneous push and pop on a non-full FIFO: both take effect; occupancy unchanged.
- reset or async reset mid-operation: pending entries discarded, no event emitted on that edge.
- Channels are fully independent; no cross-channel arbitration.

Test Plan:
1. Async reset, then reset released. Expect counter=0, running=0, ts_ready=4'hF, fifo_empty=4'hF, event_out=0.
2. start pulse at cycle 10 → running=1 after edge 10; counter reads 1 after edge 11 and 5 after edge 15. Then stop at cycle 20 → counter holds at 9 (increments on edges 11–19); counter and running stay unchanged after a second stop.
3. Push timestamps 20, 25, 25 to channel 0 while counter=5 and running. Expect:
   - event_out[0] high the cycle after counter=20, and the cycle after counter=25;
   - another pulse the next cycle, with late_err[0]=1;
   - fifo_empty[0]=1 afterwards.
4. Push 8 entries (100..107) to channel 2 while stopped → ts_ready[2]=0 after the 8th. Then an offset_en load of 200 plus start → 8 late events on consecutive cycles, late_err[2]=1, channels 0/1/3 silent.
5. COUNTER_WIDTH=8 build: offset_en with 8'hFE, then run → counter sequence FE, FF, 00, 01. A pending entry of 8'h03 fires the cycle after counter=03, not late.
6. Channel 1 holds 3 entries; reset asserted at counter=50 → all FIFOs empty, no event_out, counter=0, running=0, late_err cleared.
